pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It generalises the decode/execute latch to any stage boundary, N issue lanes and any payload width. Over the single-lane latch it adds:
- per-lane valid bits;
- an explicit action-state output;
- saturating bubble and flush counters;
- a sticky stall-watchdog flag.

It sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB), selected by the STAGE parameter, and obeys the core-wide stall vector and exception flush.

## Interface
Parameters:
- DW, 128, payload bits per lane (operands, control, exception type, PC, link address).
- NLANE, 1, issue lanes; lane i occupies bits [i*DW +: DW].
- STAGE, 2, index of this register's producing stage in the stall vector.
- STALLW, 6, stall vector width; STAGE+1 < STALLW is required (elaboration error otherwise).
- CNTW, 16, width of the bubble/flush counters.
- HOLD_LIMIT, 1024, consecutive hold cycles that set the watchdog flag; must be ≥ 1 and < 2^16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  STALLW  core stall vector from the stall controller.
- flush  in  1  exception flush; empties the register.
- in_valid  in  NLANE  per-lane valid from the producing stage.
- in_data  in  NLANE*DW  per-lane payload.
- in_next_delayslot  in  1  the instruction now entering the producing stage is in a branch delay slot.
- out_valid  out  NLANE  registered lane valids.
- out_data  out  NLANE*DW  registered payload.
- out_delayslot  out  1  registered in_next_delayslot, returned to the producing stage.
- act  out  2  last action: RUN=0, HOLD=1, BUBBLE=2, CLEAR=3.
- bubble_cnt  out  CNTW  saturating count of bubble cycles.
- flush_cnt  out  CNTW  saturating count of flush cycles.
- stuck  out  1  sticky watchdog flag.

## Operation
Each rising edge takes exactly one action, in this priority order:
1. **rst.** Every output goes to 0: out_valid, out_data, out_delayslot, act=CLEAR, bubble_cnt, flush_cnt, stuck. The internal hold age goes to 0.
2. **flush.**
   - out_valid, out_data, out_delayslot ← 0; act ← CLEAR.
   - flush_cnt increments (saturates at all-ones); hold age ← 0.
   - stuck is not cleared.
3. **!stall[STAGE] (advance).**
   - out_valid ← in_valid; out_data ← in_data; out_delayslot ← in_next_delayslot.
   - act ← RUN; hold age ← 0.
   - Invalid lanes still latch their data bits.
4. **stall[STAGE] && !stall[STAGE+1] (bubble).**
   - All outputs except the counters are zeroed, exactly as for flush. An all-zero payload decodes downstream as NOP.
   - act ← BUBBLE; bubble_cnt increments (saturating); hold age ← 0.
5. **stall[STAGE] && stall[STAGE+1] (hold).**
   - out_valid, out_data and out_delayslot keep their values; act ← HOLD.
   - Hold age increments, saturating at HOLD_LIMIT. When it reaches HOLD_LIMIT, stuck ← 1.
   - stuck clears only on rst.

Width rules:
- Counters are unsigned and never wrap.
- The hold age is 16 bits wide internally.

Rule conflicts:
- flush together with any stall pattern → flush wins.
- rst together with flush → rst wins; flush_cnt is not incremented.

## Timing
- Latency is 1 cycle from in_* to out_*. There is no combinational path from any input to any output.
- Bubble: the cycle after the stall edge shows zeros. While the stall pattern persists, the register keeps re-bubbling every cycle; bubble_cnt increments once per such cycle.
- Hold → advance: the old payload is visible until the edge on which stall[STAGE] drops. After that edge, out_* shows the new inputs.
- stuck rises on the edge that completes the HOLD_LIMIT-th consecutive hold cycle.
- The counters and act update on the same edge as the data.

## Structure
- Package pipe_pkg holds:
  - the act encoding (pipe_act_t: RUN/HOLD/BUBBLE/CLEAR);
  - the stall-vector width constant;
  - stage index constants (IF=0 … WB=5).
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, cnt) is instantiated three times: bubble_cnt, flush_cnt and the hold age (W=16).
- The action decode is one priority block producing act_next; the data, valid and delay-slot registers are driven from act_next.

## Test plan
- **Reset:** rst=1 for 2 cycles with in_data=all-ones, in_valid=1 → all outputs 0, act=3.
- **Advance:** stall=0, in_data=0x1234…, in_valid=1, in_next_delayslot=1 → next cycle out_data=0x1234…, out_valid=1, out_delayslot=1, act=0.
- **Bubble vs hold (STAGE=2):**
  - stall=6'b000111 for 3 cycles → out_* = 0, act=2, bubble_cnt=3.
  - Then stall=6'b001111 with prior payload P → out_data stays P, act=1, bubble_cnt stays 3.
- **Flush priority:** flush=1 with stall=6'b001111 → out_* = 0, act=3, flush_cnt=1, bubble_cnt unchanged.
- **Watchdog (HOLD_LIMIT=4):**
  - stall=6'b001111 for 3 cycles → stuck=0; the 4th cycle → stuck=1.
  - A following advance keeps stuck=1; rst clears it.
- **Saturation and lanes (CNTW=2, NLANE=2):**
  - 5 bubbles → bubble_cnt=3.
  - Advance with in_valid=2'b10 → out_valid=2'b10, and lane-0 data is latched.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: action encoding,
// stall-vector geometry and stage indices.
package pipe_pkg;

  typedef enum logic [1:0] {
    ACT_RUN    = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_CLEAR  = 2'd3
  } pipe_act_t;

  localparam int unsigned STALL_W = 6;

  // Bit positions in the core stall vector
  localparam int unsigned STG_IF   = 0;
  localparam int unsigned STG_ID   = 1;
  localparam int unsigned STG_EX   = 2;
  localparam int unsigned STG_MEM  = 3;
  localparam int unsigned STG_DMEM = 4;
  localparam int unsigned STG_WB   = 5;

endpackage

// File: rtl/sat_counter.sv
// Unsigned counter that sticks at all-ones; rst and clr both return it to 0.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, never wrapping past all-ones
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with per-lane valids, stall/flush
// handling, bubble/flush statistics and a hold watchdog.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DW         = 128,
  parameter int unsigned NLANE      = 1,
  parameter int unsigned STAGE      = 2,
  parameter int unsigned STALLW     = STALL_W,
  parameter int unsigned CNTW       = 16,
  parameter int unsigned HOLD_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALLW-1:0]     stall,
  input  logic                  flush,
  input  logic [NLANE-1:0]      in_valid,
  input  logic [NLANE*DW-1:0]   in_data,
  input  logic                  in_next_delayslot,
  output logic [NLANE-1:0]      out_valid,
  output logic [NLANE*DW-1:0]   out_data,
  output logic                  out_delayslot,
  output logic [1:0]            act,
  output logic [CNTW-1:0]       bubble_cnt,
  output logic [CNTW-1:0]       flush_cnt,
  output logic                  stuck
);

  if (STAGE + 1 >= STALLW) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE+1 must be below STALLW");
  end
  if (HOLD_LIMIT < 1 || HOLD_LIMIT >= 65536) begin : g_bad_limit
    $error("pipe_stage_reg: HOLD_LIMIT must be in [1, 65535]");
  end

  localparam logic [15:0] HOLD_MAX = 16'(HOLD_LIMIT);

  pipe_act_t   act_next;
  pipe_act_t   act_q;
  logic [15:0] hold_age;
  logic        hold_inc;
  logic        hold_clr;

  // Single priority decode: rst > flush > advance > bubble > hold
  always_comb begin
    act_next = ACT_HOLD;
    if (rst || flush)                  act_next = ACT_CLEAR;
    else if (!stall[STAGE])            act_next = ACT_RUN;
    else if (!stall[STAGE+1])          act_next = ACT_BUBBLE;
    else                               act_next = ACT_HOLD;
  end

  assign hold_clr = (act_next != ACT_HOLD);
  assign hold_inc = (act_next == ACT_HOLD) && (hold_age < HOLD_MAX);

  // Payload, valids and delay-slot flag follow the decoded action
  always_ff @(posedge clk) begin
    unique case (act_next)
      ACT_RUN: begin
        out_valid     <= in_valid;
        out_data      <= in_data;
        out_delayslot <= in_next_delayslot;
      end
      ACT_HOLD: ;
      default: begin
        out_valid     <= '0;
        out_data      <= '0;
        out_delayslot <= 1'b0;
      end
    endcase
    act_q <= act_next;
  end

  // Watchdog: set on the edge completing the HOLD_LIMIT-th consecutive hold
  always_ff @(posedge clk) begin
    if (rst) begin
      stuck <= 1'b0;
    end else if (act_next == ACT_HOLD && hold_age >= HOLD_MAX - 16'd1) begin
      stuck <= 1'b1;
    end
  end

  assign act = act_q;

  sat_counter #(.W(CNTW)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (act_next == ACT_BUBBLE),
    .cnt (bubble_cnt)
  );

  sat_counter #(.W(CNTW)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (act_next == ACT_CLEAR),
    .cnt (flush_cnt)
  );

  sat_counter #(.W(16)) u_hold_age (
    .clk (clk),
    .rst (rst),
    .clr (hold_clr),
    .inc (hold_inc),
    .cnt (hold_age)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed vector table followed by random
// stimulus checked against a rule-level reference model.
module tb_pipe_stage_reg;

  localparam int unsigned DW    = 32;
  localparam int unsigned NLANE = 2;
  localparam int unsigned CNTW  = 2;
  localparam int unsigned LIM   = 4;
  localparam int          CMAX  = (1 << CNTW) - 1;

  logic        clk = 1'b0;
  logic        rst, flush, in_next_delayslot;
  logic [5:0]  stall;
  logic [1:0]  in_valid;
  logic [63:0] in_data;
  logic [1:0]  out_valid;
  logic [63:0] out_data;
  logic        out_delayslot;
  logic [1:0]  act;
  logic [1:0]  bubble_cnt, flush_cnt;
  logic        stuck;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DW(DW), .NLANE(NLANE), .STAGE(2), .STALLW(6), .CNTW(CNTW), .HOLD_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_next_delayslot(in_next_delayslot),
    .out_valid(out_valid), .out_data(out_data), .out_delayslot(out_delayslot),
    .act(act), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .stuck(stuck)
  );

  typedef struct {
    logic        rst, flush;
    logic [5:0]  stall;
    logic [1:0]  vld;
    logic [63:0] data;
    logic        ds;
    logic [1:0]  e_vld;
    logic [63:0] e_data;
    logic        e_ds;
    logic [1:0]  e_act, e_b, e_f;
    logic        e_stuck;
  } vec_t;

  // Reference model state (plain integers, rule-level)
  logic [1:0]  m_vld;
  logic [63:0] m_data;
  logic        m_ds, m_stuck;
  int          m_act, m_b, m_f, m_run;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Apply one cycle of inputs, advance the model, sample after the edge
  task automatic step(input logic r, input logic f, input logic [5:0] s,
                      input logic [1:0] v, input logic [63:0] d, input logic ds,
                      input bit check_model);
    rst = r; flush = f; stall = s; in_valid = v; in_data = d; in_next_delayslot = ds;
    if (r) begin
      m_vld = '0; m_data = '0; m_ds = 0; m_act = 3; m_b = 0; m_f = 0; m_run = 0; m_stuck = 0;
    end else if (f) begin
      m_vld = '0; m_data = '0; m_ds = 0; m_act = 3; m_f = sat_inc(m_f, CMAX); m_run = 0;
    end else if (!s[2]) begin
      m_vld = v; m_data = d; m_ds = ds; m_act = 0; m_run = 0;
    end else if (!s[3]) begin
      m_vld = '0; m_data = '0; m_ds = 0; m_act = 2; m_b = sat_inc(m_b, CMAX); m_run = 0;
    end else begin
      m_act = 1; m_run = sat_inc(m_run, LIM);
      if (m_run == LIM) m_stuck = 1;
    end
    @(posedge clk);
    #1;
    if (check_model) begin
      chk("rnd.out_valid", 64'(out_valid), 64'(m_vld));
      chk("rnd.out_data", out_data, m_data);
      chk("rnd.out_delayslot", 64'(out_delayslot), 64'(m_ds));
      chk("rnd.act", 64'(act), 64'(m_act));
      chk("rnd.bubble_cnt", 64'(bubble_cnt), 64'(m_b));
      chk("rnd.flush_cnt", 64'(flush_cnt), 64'(m_f));
      chk("rnd.stuck", 64'(stuck), 64'(m_stuck));
    end
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic [5:0] s,
                              input logic [1:0] v, input logic [63:0] d, input logic ds,
                              input logic [1:0] ev, input logic [63:0] ed, input logic eds,
                              input logic [1:0] ea, input logic [1:0] eb, input logic [1:0] ef,
                              input logic es);
    vec_t t;
    t.rst = r; t.flush = f; t.stall = s; t.vld = v; t.data = d; t.ds = ds;
    t.e_vld = ev; t.e_data = ed; t.e_ds = eds; t.e_act = ea; t.e_b = eb; t.e_f = ef;
    t.e_stuck = es;
    return t;
  endfunction

  localparam logic [63:0] ONES = '1;
  localparam logic [63:0] A    = 64'h12345678_9abcdef0;
  localparam logic [63:0] P    = 64'hcafef00d_0badbeef;
  localparam logic [63:0] J    = 64'h11112222_33334444;
  localparam logic [63:0] L    = 64'h55aa55aa_deadbeef;
  localparam logic [63:0] D    = 64'h0f0f0f0f_a5a5a5a5;

  vec_t tbl[28];

  initial begin
    //             rst flush stall     vld    data  ds | e_vld e_data e_ds act b  f  stuck
    tbl[0]  = mk(1, 0, 6'b000000, 2'b11, ONES, 1, 2'b00, 64'd0, 0, 3, 0, 0, 0);
    tbl[1]  = mk(1, 0, 6'b000000, 2'b11, ONES, 1, 2'b00, 64'd0, 0, 3, 0, 0, 0);
    tbl[2]  = mk(0, 0, 6'b000000, 2'b01, A,    1, 2'b01, A,     1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 6'b000111, 2'b11, J,    1, 2'b00, 64'd0, 0, 2, 1, 0, 0);
    tbl[4]  = mk(0, 0, 6'b000111, 2'b11, J,    1, 2'b00, 64'd0, 0, 2, 2, 0, 0);
    tbl[5]  = mk(0, 0, 6'b000111, 2'b11, J,    1, 2'b00, 64'd0, 0, 2, 3, 0, 0);
    tbl[6]  = mk(0, 0, 6'b000000, 2'b11, P,    0, 2'b11, P,     0, 0, 3, 0, 0);
    tbl[7]  = mk(0, 0, 6'b001111, 2'b00, J,    1, 2'b11, P,     0, 1, 3, 0, 0);
    tbl[8]  = mk(0, 0, 6'b001111, 2'b00, J,    1, 2'b11, P,     0, 1, 3, 0, 0);
    tbl[9]  = mk(0, 0, 6'b001111, 2'b00, J,    1, 2'b11, P,     0, 1, 3, 0, 0);
    tbl[10] = mk(0, 0, 6'b001111, 2'b00, J,    1, 2'b11, P,     0, 1, 3, 0, 1);
    tbl[11] = mk(0, 0, 6'b001111, 2'b00, J,    1, 2'b11, P,     0, 1, 3, 0, 1);
    tbl[12] = mk(0, 1, 6'b001111, 2'b11, J,    1, 2'b00, 64'd0, 0, 3, 3, 1, 1);
    tbl[13] = mk(0, 0, 6'b000000, 2'b10, L,    0, 2'b10, L,     0, 0, 3, 1, 1);
    tbl[14] = mk(0, 0, 6'b000111, 2'b11, J,    1, 2'b00, 64'd0, 0, 2, 3, 1, 1);
    tbl[15] = mk(0, 0, 6'b000111, 2'b11, J,    1, 2'b00, 64'd0, 0, 2, 3, 1, 1);
    tbl[16] = mk(0, 1, 6'b000000, 2'b11, J,    1, 2'b00, 64'd0, 0, 3, 3, 2, 1);
    tbl[17] = mk(0, 1, 6'b000111, 2'b11, J,    1, 2'b00, 64'd0, 0, 3, 3, 3, 1);
    tbl[18] = mk(0, 1, 6'b000000, 2'b11, J,    1, 2'b00, 64'd0, 0, 3, 3, 3, 1);
    tbl[19] = mk(1, 1, 6'b001111, 2'b11, J,    1, 2'b00, 64'd0, 0, 3, 0, 0, 0);
    tbl[20] = mk(0, 0, 6'b001111, 2'b11, J,    1, 2'b00, 64'd0, 0, 1, 0, 0, 0);
    tbl[21] = mk(0, 0, 6'b001111, 2'b11, J,    1, 2'b00, 64'd0, 0, 1, 0, 0, 0);
    tbl[22] = mk(0, 0, 6'b110011, 2'b01, A,    1, 2'b01, A,     1, 0, 0, 0, 0);
    tbl[23] = mk(0, 0, 6'b001100, 2'b10, J,    0, 2'b01, A,     1, 1, 0, 0, 0);
    tbl[24] = mk(0, 0, 6'b001100, 2'b10, J,    0, 2'b01, A,     1, 1, 0, 0, 0);
    tbl[25] = mk(0, 0, 6'b001100, 2'b10, J,    0, 2'b01, A,     1, 1, 0, 0, 0);
    tbl[26] = mk(0, 0, 6'b001100, 2'b10, J,    0, 2'b01, A,     1, 1, 0, 0, 1);
    tbl[27] = mk(0, 0, 6'b001000, 2'b00, D,    0, 2'b00, D,     0, 0, 0, 0, 1);

    rst = 1; flush = 0; stall = '0; in_valid = '0; in_data = '0; in_next_delayslot = 0;
    m_vld = '0; m_data = '0; m_ds = 0; m_act = 3; m_b = 0; m_f = 0; m_run = 0; m_stuck = 0;

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].stall, tbl[i].vld, tbl[i].data, tbl[i].ds, 1'b0);
      chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].e_vld));
      chk($sformatf("vec%0d.out_data", i), out_data, tbl[i].e_data);
      chk($sformatf("vec%0d.out_delayslot", i), 64'(out_delayslot), 64'(tbl[i].e_ds));
      chk($sformatf("vec%0d.act", i), 64'(act), 64'(tbl[i].e_act));
      chk($sformatf("vec%0d.bubble_cnt", i), 64'(bubble_cnt), 64'(tbl[i].e_b));
      chk($sformatf("vec%0d.flush_cnt", i), 64'(flush_cnt), 64'(tbl[i].e_f));
      chk($sformatf("vec%0d.stuck", i), 64'(stuck), 64'(tbl[i].e_stuck));
    end

    // Random phase; stall patterns biased so long holds and stuck occur
    step(1'b1, 1'b0, 6'b0, 2'b0, 64'd0, 1'b0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  s;
      logic [63:0] d;
      int unsigned k;
      k = $urandom_range(0, 9);
      s = 6'($urandom);
      if (k < 5)      s[3:2] = 2'b11;
      else if (k < 7) s[3:2] = 2'b01;
      d = {$urandom, $urandom};
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 11) == 0), s,
           2'($urandom), d, 1'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
